// File: rtl/depth_scheduler.sv
// Round-robin scheduler sharing one restoring stereo-depth divider among N_REQ requesters.
// Optional statistics counters are enabled by defining DEPTH_SCHED_STATS_EN.
module depth_scheduler #(
   parameter  int N_REQ             = 2,
   parameter  int FOCAL_LENGTH      = 1,
   parameter  int BASELINE_DISTANCE = 1,
   parameter  int NUM_W             = 16,
   localparam int ID_W              = $clog2(N_REQ)
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic [N_REQ-1:0]    req_valid_in,
   input  logic [N_REQ*12-1:0] x_1_in,
   input  logic [N_REQ*12-1:0] x_2_in,
   output logic [N_REQ-1:0]    req_ready_out,
   output logic                depth_valid_out,
   input  logic                depth_ready_in,
   output logic [7:0]          depth_out,
   output logic [ID_W-1:0]     depth_id_out,
   output logic                depth_sat_out,
`ifdef DEPTH_SCHED_STATS_EN
   output logic [15:0]         done_count_out,
   output logic [15:0]         sat_count_out,
`endif
   output logic                busy_out
);

   localparam int              CNT_W = $clog2(NUM_W);
   localparam logic [NUM_W-1:0] NUMER = NUM_W'(FOCAL_LENGTH * BASELINE_DISTANCE);

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

   state_e           stateQ, stateD;
   logic [ID_W-1:0]  rrPtrQ, idQ, nextPtr;
   logic [11:0]      divQ, remQ, remNext;
   logic [NUM_W-1:0] quotQ, quotNext;
   logic [CNT_W-1:0] cntQ;
   logic [7:0]       depthQ;
   logic             satQ;

   logic [N_REQ-1:0] rawGrant;
   logic             found;
   int               selIdx;
   logic [11:0]      selX1, selX2;
   logic [12:0]      diffComb, remShift, remSub;
   logic             nonPos, transfer, handshake, lastStep, quotSat;

   // First valid requester at or after the round-robin pointer wins the grant.
   always_comb begin
      rawGrant = '0;
      found    = 1'b0;
      selIdx   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && req_valid_in[(int'(rrPtrQ) + k) % N_REQ]) begin
            found            = 1'b1;
            selIdx           = (int'(rrPtrQ) + k) % N_REQ;
            rawGrant[selIdx] = 1'b1;
         end
      end
   end

   assign selX1     = x_1_in[selIdx*12 +: 12];
   assign selX2     = x_2_in[selIdx*12 +: 12];
   assign diffComb  = {1'b0, selX1} - {1'b0, selX2};
   assign nonPos    = diffComb[12] | (diffComb == '0);
   assign transfer  = (stateQ == IDLE) & found;
   assign handshake = (stateQ == DONE) & depth_ready_in;
   assign lastStep  = (cntQ == CNT_W'(NUM_W - 1));
   assign nextPtr   = (idQ == ID_W'(N_REQ - 1)) ? '0 : idQ + 1'b1;

   // Restoring step: a negative trial subtraction means the divisor did not fit.
   assign remShift = {remQ, quotQ[NUM_W-1]};
   assign remSub   = remShift - {1'b0, divQ};
   assign remNext  = remSub[12] ? remShift[11:0] : remSub[11:0];
   assign quotNext = {quotQ[NUM_W-2:0], ~remSub[12]};
   assign quotSat  = (quotNext > NUM_W'(255));

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) stateQ <= IDLE;
      else           stateQ <= stateD;
   end

   always_comb begin
      stateD = stateQ;
      case (stateQ)
         IDLE:    if (transfer) stateD = nonPos ? DONE : DIV;
         DIV:     if (lastStep) stateD = DONE;
         DONE:    if (depth_ready_in) stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   always_comb begin
      req_ready_out   = (stateQ == IDLE) ? rawGrant : '0;
      depth_valid_out = (stateQ == DONE);
      busy_out        = (stateQ != IDLE);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rrPtrQ <= '0;
         idQ    <= '0;
         divQ   <= '0;
         remQ   <= '0;
         quotQ  <= '0;
         cntQ   <= '0;
         depthQ <= '0;
         satQ   <= 1'b0;
      end else begin
         case (stateQ)
            IDLE: begin
               if (transfer) begin
                  idQ <= ID_W'(selIdx);
                  if (nonPos) begin
                     depthQ <= 8'hFF;
                     satQ   <= 1'b1;
                  end else begin
                     divQ  <= diffComb[11:0];
                     remQ  <= '0;
                     quotQ <= NUMER;
                     cntQ  <= '0;
                  end
               end
            end
            DIV: begin
               remQ  <= remNext;
               quotQ <= quotNext;
               cntQ  <= cntQ + 1'b1;
               if (lastStep) begin
                  depthQ <= quotSat ? 8'hFF : quotNext[7:0];
                  satQ   <= quotSat;
               end
            end
            DONE: if (handshake) rrPtrQ <= nextPtr;
            default: ;
         endcase
      end
   end

   assign depth_out     = depthQ;
   assign depth_id_out  = idQ;
   assign depth_sat_out = satQ;

`ifdef DEPTH_SCHED_STATS_EN
   logic [15:0] doneCntQ, satCntQ;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         doneCntQ <= '0;
         satCntQ  <= '0;
      end else if (handshake) begin
         doneCntQ <= doneCntQ + 16'd1;
         if (satQ) satCntQ <= satCntQ + 16'd1;
      end
   end

   assign done_count_out = doneCntQ;
   assign sat_count_out  = satCntQ;
`endif

endmodule

// File: tb/tb_depth_scheduler.sv
// Directed self-checking bench for depth_scheduler (FOCAL_LENGTH=100, BASELINE_DISTANCE=6, N_REQ=2).
module tb_depth_scheduler;

   logic        clk = 1'b0;
   logic        rstN;
   logic [1:0]  reqValid;
   logic [23:0] x1;
   logic [23:0] x2;
   logic [1:0]  reqReady;
   logic        depthValid;
   logic        depthReady;
   logic [7:0]  depth;
   logic        depthId;
   logic        depthSat;
   logic        busy;
`ifdef DEPTH_SCHED_STATS_EN
   logic [15:0] doneCount;
   logic [15:0] satCount;
`endif

   int checkCount = 0;
   int errorCount = 0;

   depth_scheduler #(
      .N_REQ(2), .FOCAL_LENGTH(100), .BASELINE_DISTANCE(6), .NUM_W(16)
   ) dut (
      .clk_in          (clk),
      .rst_n_in        (rstN),
      .req_valid_in    (reqValid),
      .x_1_in          (x1),
      .x_2_in          (x2),
      .req_ready_out   (reqReady),
      .depth_valid_out (depthValid),
      .depth_ready_in  (depthReady),
      .depth_out       (depth),
      .depth_id_out    (depthId),
      .depth_sat_out   (depthSat),
`ifdef DEPTH_SCHED_STATS_EN
      .done_count_out  (doneCount),
      .sat_count_out   (satCount),
`endif
      .busy_out        (busy)
   );

   always #5 clk = ~clk;

   // Drives one requester's coordinates and raises only its valid.
   task automatic applyStimulus(input int idx, input logic [11:0] a, input logic [11:0] b);
      x1[idx*12 +: 12] = a;
      x2[idx*12 +: 12] = b;
      reqValid         = '0;
      reqValid[idx]    = 1'b1;
   endtask

   // Counts negedges after the transfer cycle until the result appears; -1 if it never does.
   task automatic waitResult(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) reqValid = '0;
         if (depthValid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic acceptResult();
      depthReady = 1'b1;
      @(negedge clk);
      depthReady = 1'b0;
   endtask

   task automatic test_reset();
      rstN = 1'b0; reqValid = '0; x1 = '0; x2 = '0; depthReady = 1'b0;
      repeat (2) @(negedge clk);
      checkCount++;
      if ({reqReady, depthValid, depth, depthId, depthSat, busy} !== 14'd0) begin
         errorCount++;
         $display("[TB] FAIL reset_outputs: got %b required 0",
                  {reqReady, depthValid, depth, depthId, depthSat, busy});
      end
`ifdef DEPTH_SCHED_STATS_EN
      checkCount++;
      if (doneCount !== 16'd0 || satCount !== 16'd0) begin
         errorCount++;
         $display("[TB] FAIL reset_stats: got %0d/%0d required 0/0", doneCount, satCount);
      end
`endif
      rstN = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat;
      applyStimulus(0, 12'd110, 12'd100);
      #1;
      checkCount++;
      if (reqReady !== 2'b01) begin
         errorCount++; $display("[TB] FAIL basic_grant: got %b required 01", reqReady);
      end
      waitResult(lat);
      checkCount++;
      if (lat !== 17 || depth !== 8'd60 || depthId !== 1'b0 || depthSat !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL basic_result: got lat=%0d depth=%0d id=%0d sat=%0d required 17/60/0/0",
                  lat, depth, depthId, depthSat);
      end
      acceptResult();
      checkCount++;
      if (depthValid !== 1'b0 || busy !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL basic_release: got valid=%0d busy=%0d required 0/0", depthValid, busy);
      end
   endtask

   task automatic test_saturate();
      int lat;
      applyStimulus(1, 12'd102, 12'd100);
      #1;
      checkCount++;
      if (reqReady !== 2'b10) begin
         errorCount++; $display("[TB] FAIL sat_grant: got %b required 10", reqReady);
      end
      waitResult(lat);
      checkCount++;
      if (lat !== 17 || depth !== 8'd255 || depthId !== 1'b1 || depthSat !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL sat_result: got lat=%0d depth=%0d id=%0d sat=%0d required 17/255/1/1",
                  lat, depth, depthId, depthSat);
      end
      acceptResult();
   endtask

   task automatic test_nonpositive();
      int lat;
      applyStimulus(0, 12'd200, 12'd200);
      waitResult(lat);
      checkCount++;
      if (lat !== 1 || depth !== 8'd255 || depthSat !== 1'b1 || depthId !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL zero_disp: got lat=%0d depth=%0d sat=%0d id=%0d required 1/255/1/0",
                  lat, depth, depthSat, depthId);
      end
      acceptResult();
      applyStimulus(1, 12'd50, 12'd80);
      waitResult(lat);
      checkCount++;
      if (lat !== 1 || depth !== 8'd255 || depthSat !== 1'b1 || depthId !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL neg_disp: got lat=%0d depth=%0d sat=%0d id=%0d required 1/255/1/1",
                  lat, depth, depthSat, depthId);
      end
      acceptResult();
   endtask

   task automatic test_stall();
      int lat;
      int bad = 0;
      applyStimulus(0, 12'd120, 12'd100);
      waitResult(lat);
      checkCount++;
      if (lat !== 17 || depth !== 8'd30) begin
         errorCount++;
         $display("[TB] FAIL stall_result: got lat=%0d depth=%0d required 17/30", lat, depth);
      end
      reqValid = 2'b11;
      for (int c = 0; c < 5; c++) begin
         if (c != 0) @(negedge clk);
         #1;
         if (depthValid !== 1'b1 || depth !== 8'd30 || depthSat !== 1'b0 || reqReady !== 2'b00) bad++;
      end
      checkCount++;
      if (bad != 0) begin
         errorCount++;
         $display("[TB] FAIL stall_hold: got %0d unstable cycles required 0", bad);
      end
      @(negedge clk);
      reqValid   = '0;
      depthReady = 1'b1;
      @(negedge clk);
      depthReady = 1'b0;
      checkCount++;
      if (depthValid !== 1'b0 || busy !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL stall_accept: got valid=%0d busy=%0d required 0/0", depthValid, busy);
      end
   endtask

   task automatic test_back_to_back();
      int jobs = 0;
      int pending = 0;
      int cyc = 0;
      rstN = 1'b0;
      @(negedge clk);
      x1 = {12'd130, 12'd110};
      x2 = {12'd100, 12'd100};
      reqValid   = 2'b11;
      depthReady = 1'b1;
      rstN       = 1'b1;
      while (jobs < 4 && cyc < 300) begin
         #1;
         if (reqReady !== 2'b00) begin
            pending++;
            checkCount++;
            if (reqReady !== ((jobs % 2 == 0) ? 2'b01 : 2'b10) || pending > 1) begin
               errorCount++;
               $display("[TB] FAIL rr_grant: job %0d got %b pending=%0d", jobs, reqReady, pending);
            end
         end
         if (depthValid) begin
            checkCount++;
            if (depthId !== jobs[0] || depth !== ((jobs % 2 == 0) ? 8'd60 : 8'd20)) begin
               errorCount++;
               $display("[TB] FAIL rr_result: job %0d got id=%0d depth=%0d", jobs, depthId, depth);
            end
            pending--;
            jobs++;
         end
         @(negedge clk);
         cyc++;
      end
      checkCount++;
      if (jobs != 4) begin
         errorCount++; $display("[TB] FAIL rr_timeout: got %0d jobs required 4", jobs);
      end
      reqValid   = '0;
      depthReady = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_div();
      int lat;
      applyStimulus(0, 12'd110, 12'd100);
      @(negedge clk);
      reqValid = '0;
      repeat (7) @(negedge clk);
      rstN = 1'b0;
      #1;
      checkCount++;
      if ({reqReady, depthValid, depth, depthId, depthSat, busy} !== 14'd0) begin
         errorCount++;
         $display("[TB] FAIL midreset_outputs: got %b required 0",
                  {reqReady, depthValid, depth, depthId, depthSat, busy});
      end
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(1, 12'd112, 12'd100);
      #1;
      checkCount++;
      if (reqReady !== 2'b10) begin
         errorCount++; $display("[TB] FAIL midreset_grant: got %b required 10", reqReady);
      end
`ifdef DEPTH_SCHED_STATS_EN
      checkCount++;
      if (doneCount !== 16'd0) begin
         errorCount++; $display("[TB] FAIL stats_zero: got %0d required 0", doneCount);
      end
`endif
      waitResult(lat);
      checkCount++;
      if (lat !== 17 || depth !== 8'd50 || depthId !== 1'b1 || depthSat !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL midreset_result: got lat=%0d depth=%0d id=%0d sat=%0d required 17/50/1/0",
                  lat, depth, depthId, depthSat);
      end
      acceptResult();
`ifdef DEPTH_SCHED_STATS_EN
      checkCount++;
      if (doneCount !== 16'd1 || satCount !== 16'd0) begin
         errorCount++;
         $display("[TB] FAIL stats_one: got %0d/%0d required 1/0", doneCount, satCount);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturate();
      test_nonpositive();
      test_stall();
      test_back_to_back();
      test_reset_mid_div();
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
